// File: rtl/irq_controller.sv
// irq_controller: external interrupt entry/return sequencer for the 5-stage
// pipeline. Synchronizes and edge-detects the interrupt lines, latches them
// as pending, picks the lowest-index enabled source, accepts it only at a
// safe point in ID, and blocks further accepts until eret retires.
module irq_controller #(
  parameter int          N_IRQ     = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0080,
  parameter int          VEC_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             ie,
  input  logic             id_valid,
  input  logic             stall_id,
  input  logic             redirect_id,
  input  logic             eret_id,
  input  logic [31:0]      pc_id,
  output logic             inta,
  output logic [31:0]      vector,
  output logic [31:0]      epc,
  output logic [2:0]       irq_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVICE = 2'b01,
    RETURN  = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [N_IRQ-1:0] s1_reg, s2_reg, prev_reg;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] rise, req, clr;
  logic [31:0]      epc_reg;
  logic [2:0]       irq_id_reg;
  logic [2:0]       winner;
  logic             safe, accept;

  // Two-flop synchronizer plus one delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      prev_reg <= '0;
    end else begin
      s1_reg   <= irq;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~prev_reg;
  assign req  = pending_reg & irq_mask & {N_IRQ{ie}};
  assign safe = id_valid & ~stall_id & ~redirect_id & ~eret_id;

  // Fixed priority: the lowest set request index wins.
  always_comb begin
    winner = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = 3'(i);
    end
  end

  // Accept is only possible from IDLE; held off while reset is asserted.
  assign accept = (state_reg == IDLE) & (|req) & safe & ~rst;

  // One-hot clear of the accepted source's pending bit.
  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_clr
      assign clr[gi] = accept & (winner == 3'(gi));
    end
  endgenerate

  // A new edge on the bit being cleared wins over the clear.
  assign pending_next = (pending_reg & ~clr) | rise;

  // Pending latch, saved return PC and accepted source index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      epc_reg     <= 32'd0;
      irq_id_reg  <= 3'd0;
    end else begin
      pending_reg <= pending_next;
      if (accept) begin
        epc_reg    <= pc_id;
        irq_id_reg <= winner;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and Mealy accept pulse.
  always_comb begin
    state_next = state_reg;
    inta       = 1'b0;
    case (state_reg)
      IDLE: begin
        inta = accept;
        if (accept) state_next = SERVICE;
      end
      SERVICE: begin
        if (eret_id && !stall_id) state_next = RETURN;
      end
      RETURN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign vector     = rst ? VEC_BASE : VEC_BASE + (32'(winner) << VEC_SHIFT);
  assign epc        = epc_reg;
  assign irq_id     = irq_id_reg;
  assign pending    = pending_reg;
  assign in_service = (state_reg == SERVICE) || (state_reg == RETURN);

endmodule

// File: doc/irq_controller.md
# irq_controller

Sequences external interrupt entry and return for the 5-stage MIPS pipeline. Synchronizes and edge-detects external interrupt lines, latches them as pending, and picks the highest-priority enabled source. Picks a safe point in ID, then raises a one-cycle `inta` to the hazard detection unit, which flushes IF/ID and ID/EX. Captures EPC and the handler vector, and blocks further entries until `eret` retires.

## Interface
- `N_IRQ`, 4: number of interrupt lines; must be 1..8.
- `VEC_BASE`, 32'h0000_0080: handler vector base address.
- `VEC_SHIFT`, 4: log2 byte stride between per-source vectors.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `irq` in N_IRQ: external interrupt lines, asynchronous, rising-edge significant.
- `irq_mask` in N_IRQ: per-source enable (CP0 Status IM); 1 = enabled.
- `ie` in 1: global interrupt enable (CP0 Status IE).
- `id_valid` in 1: ID holds a real instruction (not a bubble).
- `stall_id` in 1: hazard unit is holding ID this cycle (`pc_write` low).
- `redirect_id` in 1: branch, jump or eret redirect flushing IF/ID this cycle.
- `eret_id` in 1: eret decoded in ID.
- `pc_id` in 32: PC of the instruction in ID.
- `inta` out 1: interrupt accept; one-cycle pulse to the hazard unit and PC mux.
- `vector` out 32: handler address; valid while `inta`=1.
- `epc` out 32: saved return PC.
- `irq_id` out 3: index of the accepted source, registered at accept.
- `in_service` out 1: handler is running.
- `pending` out N_IRQ: latched pending bits.

## Operation
- **Synchronizer:** `s1 <= irq`, `s2 <= s1`, `prev <= s2`.
  - `rise = s2 & ~prev`.
  - `pending[i]` sets at the clock edge where `rise[i]` is high.
- **Request:** `req = pending & irq_mask`, gated by `ie`.
  - Winner is the lowest set index (index 0 has highest priority).
- **Safe point:** `safe = id_valid & ~stall_id & ~redirect_id & ~eret_id`.
- **States:**
  - **IDLE:**
    - `inta = ie & |req & safe`, a Mealy output.
    - On `inta` at the edge: `epc <= pc_id`, `irq_id <=` winner, `pending[winner] <= 0`, go to SERVICE.
    - The ID instruction is flushed and not executed; eret re-executes it.
  - **SERVICE:**
    - `inta` = 0 and `in_service` = 1; new edges keep accumulating in `pending`.
    - On `eret_id & ~stall_id`: go to RETURN.
  - **RETURN:**
    - One cycle, `inta` = 0, covering the eret redirect in flight.
    - Next state is always IDLE. `in_service` drops entering IDLE.
- **Vector:** `vector = VEC_BASE + (winner << VEC_SHIFT)`, computed in 32 bits.
- **Pending set and clear in the same cycle on the same bit:** set wins.
- **`eret_id` while in IDLE:** ignored.
- **Mask or `ie` drops while waiting in IDLE:** no accept; `pending` stays latched.
- **Encoding:** state is 2-bit; the unused code returns to IDLE.

## Timing
- **Reset values:** state IDLE; `s1`, `s2`, `prev`, `pending`, `epc`, `irq_id` all 0; `in_service` 0.
  - `inta` is forced 0 while `rst` is high, and `vector` = `VEC_BASE`.
- **Latency:**
  - `irq` is high at edge E0.
  - `rise` is high in the cycle after E1; `pending` is visible after E2.
  - Earliest `inta` is the cycle between E2 and E3; SERVICE is entered after E3.
- **Pulse width:** `inta` is never high for two consecutive cycles. Minimum gap between two accepts is eret + RETURN + 1 cycle.
- **Edge filtering:** an `irq` pulse shorter than one clock may be missed. A line held high produces exactly one pending set.
- **Reset mid-operation:** reset in SERVICE or RETURN returns to IDLE immediately (asynchronous) and discards `pending` and `epc`.

## Test plan
- **Basic entry:**
  - Stimulus: reset, then `irq`=4'b0100, `irq_mask`=4'hF, `ie`=1, `safe` always, `pc_id`=32'h0040_0010.
  - Required: `inta` pulses exactly once, 3 cycles after `irq`; `vector`=32'h0000_00A0; `epc`=32'h0040_0010; `irq_id`=2; `pending`=0.
- **Priority:**
  - Stimulus: `irq` bits 1 and 3 rise on the same edge.
  - Required: first accept has `irq_id`=1 and `vector`=32'h0000_0090, and `pending`=4'b1000 stays.
  - After eret + RETURN, the second accept has `irq_id`=3 and `vector`=32'h0000_00B0.
- **Stall and redirect deferral:**
  - Stimulus: `pending` set while `stall_id`=1 for 2 cycles, then `redirect_id`=1 for 1 cycle.
  - Required: `inta` stays 0 throughout and asserts in the first fully safe cycle; `epc` equals `pc_id` of that cycle.
- **Masking:**
  - Stimulus: `irq[0]` rises with `irq_mask[0]`=0, `ie`=1.
  - Required: `pending`=4'b0001, no `inta`; setting `irq_mask[0]`=1 produces `inta` in the next safe cycle.
- **Nesting block:**
  - Stimulus: in SERVICE, `irq[2]` rises.
  - Required: no `inta` until eret, then RETURN for 1 cycle, then `inta` in IDLE; `eret_id` in IDLE changes nothing.
- **Asynchronous reset:**
  - Stimulus: assert `rst` mid-cycle while in SERVICE with `pending`=4'b0110.
  - Required: `in_service`, `pending` and `epc` go to 0 without a clock edge; no `inta` after release until a new rising `irq`.
